// File: rtl/fruit_pkg.sv
// Shared definitions for the fruit sorting pipeline: sort code range, scheduler
// states and small arithmetic helpers.
package fruit_pkg;

  localparam int         SORT_CODE_W = 4;
  localparam logic [3:0] SORT_NONE   = 4'd0;
  localparam logic [3:0] SORT_MAX    = 4'd11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_SETTLE  = 3'd2,
    S_SAMPLE  = 3'd3,
    S_VOTE    = 3'd4,
    S_PUBLISH = 3'd5
  } sched_state_t;

  // Saturating 8-bit increment used for event counters.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    logic [7:0] result;
    if (value == 8'hFF) begin
      result = 8'hFF;
    end else begin
      result = value + 8'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/vsync_edge_detect.sv
// Frame edge detector: registers the vsync level once and flags the cycle in
// which vsync enters its active level.
module vsync_edge_detect #(
  parameter logic VS_POL = 1'b1
) (
  input  logic pixelclk,
  input  logic reset_n,
  input  logic vsync,
  output logic frame_edge
);

  logic level_r;

  // Previous-cycle vsync level; resets to inactive.
  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      level_r <= ~VS_POL;
    end else begin
      level_r <= vsync;
    end
  end

  assign frame_edge = (level_r != VS_POL) && (vsync == VS_POL);

endmodule

// File: rtl/sort_result_scheduler.sv
// Frame-rate scheduler: samples the classifier sort code once per frame after a
// settle delay, confirms it by consecutive-frame voting and publishes it over valid/ready.
module sort_result_scheduler
  import fruit_pkg::*;
#(
  parameter int                SORT_W         = 4,
  parameter int                CONFIRM_FRAMES = 3,
  parameter int                SETTLE_CYCLES  = 4,
  parameter logic              VS_POL         = 1'b1,
  parameter logic [SORT_W-1:0] NONE_CODE      = SORT_W'(SORT_NONE)
) (
  input  logic              pixelclk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              i_vsync,
  input  logic [SORT_W-1:0] i_sort,
  input  logic              i_result_ready,
  output logic [SORT_W-1:0] o_result,
  output logic              o_result_valid,
  output logic              o_changed,
  output logic [7:0]        o_dropped
);

  localparam int VOTE_W = $clog2(CONFIRM_FRAMES + 1);
  localparam int CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [VOTE_W-1:0] VOTE_MAX    = VOTE_W'(CONFIRM_FRAMES);
  localparam logic [VOTE_W-1:0] VOTE_ONE    = VOTE_W'(1);
  localparam logic [VOTE_W-1:0] VOTE_ZERO   = VOTE_W'(0);
  localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO    = CNT_W'(0);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);

  sched_state_t      state_r, state_s;
  logic [CNT_W-1:0]  settle_cnt_r, settle_cnt_s;
  logic [SORT_W-1:0] sample_r, sample_s;
  logic [SORT_W-1:0] cand_r, cand_s;
  logic [VOTE_W-1:0] vote_r, vote_s;
  logic [SORT_W-1:0] result_r, result_s;
  logic              valid_r, valid_s;
  logic              changed_r, changed_s;
  logic [7:0]        dropped_r, dropped_s;
  logic              frame_edge_s;
  logic              busy_s;

  vsync_edge_detect #(
    .VS_POL(VS_POL)
  ) u_edge (
    .pixelclk  (pixelclk),
    .reset_n   (reset_n),
    .vsync     (i_vsync),
    .frame_edge(frame_edge_s)
  );

  assign busy_s = (state_r == S_SETTLE) || (state_r == S_SAMPLE) ||
                  (state_r == S_VOTE)   || (state_r == S_PUBLISH);

  // Next-state and datapath updates for the scheduling FSM.
  always_comb begin
    state_s      = state_r;
    settle_cnt_s = settle_cnt_r;
    sample_s     = sample_r;
    cand_s       = cand_r;
    vote_s       = vote_r;
    result_s     = result_r;
    valid_s      = valid_r;
    changed_s    = 1'b0;

    // Frame edges arriving mid-cycle are not re-triggered, only counted.
    if (frame_edge_s && busy_s) begin
      dropped_s = sat_inc8(dropped_r);
    end else begin
      dropped_s = dropped_r;
    end

    case (state_r)
      S_IDLE: begin
        cand_s = NONE_CODE;
        vote_s = VOTE_ZERO;
        if (enable) begin
          state_s = S_WAIT;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!enable) begin
          state_s = S_IDLE;
          cand_s  = NONE_CODE;
          vote_s  = VOTE_ZERO;
        end else if (frame_edge_s) begin
          state_s      = S_SETTLE;
          settle_cnt_s = SETTLE_LOAD;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_SETTLE: begin
        if (settle_cnt_r == CNT_ZERO) begin
          state_s = S_SAMPLE;
        end else begin
          settle_cnt_s = settle_cnt_r - CNT_ONE;
        end
      end
      S_SAMPLE: begin
        sample_s = i_sort;
        state_s  = S_VOTE;
      end
      S_VOTE: begin
        if (sample_r == cand_r) begin
          if (vote_r == VOTE_MAX) begin
            vote_s = VOTE_MAX;
          end else begin
            vote_s = vote_r + VOTE_ONE;
          end
        end else begin
          cand_s = sample_r;
          vote_s = VOTE_ONE;
        end
        // A disable seen here aborts the frame; IDLE then wipes the vote history.
        if (!enable) begin
          state_s = S_IDLE;
        end else if ((vote_s == VOTE_MAX) && (cand_s != result_r)) begin
          state_s   = S_PUBLISH;
          result_s  = cand_s;
          valid_s   = 1'b1;
          changed_s = 1'b1;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_PUBLISH: begin
        if (i_result_ready) begin
          valid_s = 1'b0;
          if (enable) begin
            state_s = S_WAIT;
          end else begin
            state_s = S_IDLE;
          end
        end else begin
          state_s = S_PUBLISH;
        end
      end
      default: begin
        state_s = S_IDLE;
        valid_s = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= S_IDLE;
      settle_cnt_r <= CNT_ZERO;
      sample_r     <= NONE_CODE;
      cand_r       <= NONE_CODE;
      vote_r       <= VOTE_ZERO;
      result_r     <= NONE_CODE;
      valid_r      <= 1'b0;
      changed_r    <= 1'b0;
      dropped_r    <= 8'd0;
    end else begin
      state_r      <= state_s;
      settle_cnt_r <= settle_cnt_s;
      sample_r     <= sample_s;
      cand_r       <= cand_s;
      vote_r       <= vote_s;
      result_r     <= result_s;
      valid_r      <= valid_s;
      changed_r    <= changed_s;
      dropped_r    <= dropped_s;
    end
  end

  assign o_result       = result_r;
  assign o_result_valid = valid_r;
  assign o_changed      = changed_r;
  assign o_dropped      = dropped_r;

endmodule

// File: tb/tb_sort_result_scheduler.sv
// Directed bench for sort_result_scheduler: default instance for voting, handshake,
// enable and reset behaviour; a fast instance (1 frame confirm, 1 cycle settle) for saturation.
module tb_sort_result_scheduler;

  logic       pixelclk;
  logic       reset_n;
  logic       enable;
  logic       vsync1, vsync2;
  logic [3:0] sort1, sort2;
  logic       ready1, ready2;
  logic [3:0] result1, result2;
  logic       valid1, valid2;
  logic       changed1, changed2;
  logic [7:0] dropped1, dropped2;

  int passed = 0;
  int total  = 0;
  int fails  = 0;
  int chg1   = 0;
  int chg2   = 0;

  sort_result_scheduler dut1 (
    .pixelclk      (pixelclk),
    .reset_n       (reset_n),
    .enable        (enable),
    .i_vsync       (vsync1),
    .i_sort        (sort1),
    .i_result_ready(ready1),
    .o_result      (result1),
    .o_result_valid(valid1),
    .o_changed     (changed1),
    .o_dropped     (dropped1)
  );

  sort_result_scheduler #(
    .CONFIRM_FRAMES(1),
    .SETTLE_CYCLES (1)
  ) dut2 (
    .pixelclk      (pixelclk),
    .reset_n       (reset_n),
    .enable        (enable),
    .i_vsync       (vsync2),
    .i_sort        (sort2),
    .i_result_ready(ready2),
    .o_result      (result2),
    .o_result_valid(valid2),
    .o_changed     (changed2),
    .o_dropped     (dropped2)
  );

  initial pixelclk = 1'b0;
  always #5 pixelclk = ~pixelclk;

  // Count o_changed pulses, sampled mid-cycle.
  always @(negedge pixelclk) begin
    if (changed1 === 1'b1) chg1++;
    if (changed2 === 1'b1) chg2++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge pixelclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One frame on dut1: vsync active for two cycles starting at the edge cycle.
  task automatic frame1(input logic [3:0] code, input int len);
    sort1  = code;
    vsync1 = 1'b1;
    tick();
    tick();
    vsync1 = 1'b0;
    repeat (len - 2) tick();
  endtask

  task automatic frame2(input logic [3:0] code, input int len);
    sort2  = code;
    vsync2 = 1'b1;
    tick();
    tick();
    vsync2 = 1'b0;
    repeat (len - 2) tick();
  endtask

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    vsync1  = 1'b0;
    vsync2  = 1'b0;
    sort1   = 4'd0;
    sort2   = 4'd0;
    ready1  = 1'b0;
    ready2  = 1'b0;
    #12;
    check("rst_result", result1, 0);
    check("rst_valid", valid1, 0);
    check("rst_changed", changed1, 0);
    check("rst_dropped", dropped1, 0);
    check("rst_result2", result2, 0);
    tick();
    reset_n = 1'b1;
    enable  = 1'b1;
    tick();

    // Three frames of code 5 publish at E+7 of the third frame.
    frame1(4'd5, 12);
    frame1(4'd5, 12);
    check("t1_no_early_valid", valid1, 0);
    sort1  = 4'd5;
    vsync1 = 1'b1;
    tick();
    tick();
    vsync1 = 1'b0;
    repeat (4) tick();
    check("t1_valid_e6", valid1, 0);
    tick();
    check("t1_valid_e7", valid1, 1);
    check("t1_result", result1, 5);
    check("t1_changed_e7", changed1, 1);
    tick();
    check("t1_changed_e8", changed1, 0);
    check("t1_valid_e8", valid1, 1);
    check("t1_dropped", dropped1, 0);
    repeat (4) tick();

    // Consumer stalls for two frames: edges dropped, result held.
    frame1(4'd5, 12);
    frame1(4'd5, 12);
    check("t3_valid_held", valid1, 1);
    check("t3_result_held", result1, 5);
    check("t3_dropped", dropped1, 2);
    ready1 = 1'b1;
    tick();
    check("t3_valid_fall", valid1, 0);
    check("t3_one_publish", chg1, 1);

    // Code 2 publishes; 5,5,2,5,5 does not; the sixth 5 does; stable 5 never republishes.
    frame1(4'd2, 12);
    frame1(4'd2, 12);
    frame1(4'd2, 12);
    check("t2_result2", result1, 2);
    check("t2_chg_a", chg1, 2);
    frame1(4'd5, 12);
    frame1(4'd5, 12);
    frame1(4'd2, 12);
    frame1(4'd5, 12);
    frame1(4'd5, 12);
    check("t2_no_pub", chg1, 2);
    check("t2_result_kept", result1, 2);
    frame1(4'd5, 12);
    check("t2_result5", result1, 5);
    check("t2_chg_b", chg1, 3);
    frame1(4'd5, 12);
    frame1(4'd5, 12);
    check("t2_no_repub", chg1, 3);
    check("t2_dropped", dropped1, 2);

    // Disable during settle on what would be the confirming frame.
    frame1(4'd2, 12);
    frame1(4'd2, 12);
    sort1  = 4'd2;
    vsync1 = 1'b1;
    tick();
    tick();
    vsync1 = 1'b0;
    enable = 1'b0;
    repeat (10) tick();
    check("t4_no_pub_disabled", chg1, 3);
    check("t4_valid_disabled", valid1, 0);
    frame1(4'd2, 12);
    frame1(4'd2, 12);
    check("t4_idle_no_drop", dropped1, 2);
    enable = 1'b1;
    tick();
    frame1(4'd2, 12);
    frame1(4'd2, 12);
    check("t4_vote_cleared", chg1, 3);
    frame1(4'd2, 12);
    check("t4_pub_after3", chg1, 4);
    check("t4_result", result1, 2);

    // Reset while in PUBLISH clears outputs without a clock edge.
    ready1 = 1'b0;
    frame1(4'd5, 12);
    frame1(4'd5, 12);
    frame1(4'd5, 12);
    frame1(4'd5, 12);
    check("t5_valid_pre", valid1, 1);
    check("t5_result_pre", result1, 5);
    check("t5_dropped_pre", dropped1, 3);
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_async_result", result1, 0);
    check("t5_async_valid", valid1, 0);
    check("t5_async_dropped", dropped1, 0);
    tick();
    tick();
    reset_n = 1'b1;
    ready1  = 1'b1;
    tick();

    // Fast instance: every differing frame publishes; stalled consumer saturates drops.
    ready2 = 1'b1;
    frame2(4'd1, 8);
    check("t6_res_f1", result2, 1);
    frame2(4'd2, 8);
    check("t6_res_f2", result2, 2);
    frame2(4'd1, 8);
    check("t6_res_f3", result2, 1);
    frame2(4'd2, 8);
    check("t6_res_f4", result2, 2);
    check("t6_chg4", chg2, 4);
    ready2 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      frame2((i % 2 == 0) ? 4'd1 : 4'd2, 8);
    end
    check("t6_dropped9", dropped2, 9);
    check("t6_res_stall", result2, 1);
    for (int i = 0; i < 290; i++) begin
      frame2((i % 2 == 0) ? 4'd1 : 4'd2, 8);
    end
    check("t6_dropped_sat", dropped2, 255);
    check("t6_valid_held", valid2, 1);
    check("t6_chg5", chg2, 5);
    ready2 = 1'b1;
    tick();
    check("t6_valid_fall", valid2, 0);
    check("t6_dut1_quiet", dropped1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
